// File: rtl/synth_pkg.sv
// Shared definitions for the synthesizer voice-allocation slice.
// Holds default sizing constants, the allocator FSM encoding and the
// note-event record that the allocator emits toward the voice engines.
package synth_pkg;
    localparam int VOICES      = 32;
    localparam int V_WIDTH     = 5;
    localparam int NOTE_WIDTH  = 7;
    localparam int VEL_WIDTH   = 7;
    // Voice field in the event record is wide enough for the largest pool (512).
    localparam int MAX_V_WIDTH = 9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_ISSUE = 2'd2
    } alloc_state_t;

    typedef struct packed {
        logic                   gate;
        logic [MAX_V_WIDTH-1:0] voice;
        logic [NOTE_WIDTH-1:0]  note;
        logic [VEL_WIDTH-1:0]   vel;
    } note_evt_t;
endpackage

// File: rtl/voice_allocator_scan_cmp.sv
// voice_scan_cmp: combinational comparator for one voice against the
// running best candidates of the current scan.
//   first       - this is voice 0; running best state is stale and ignored
//   key_on/busy/note/age - state of the voice being examined
//   req_note    - note of the latched request
//   match_found/free_found/best_age - running best so far
//   take_*      - examined voice replaces the corresponding candidate
module voice_scan_cmp #(
    parameter int NOTE_WIDTH = 7,
    parameter int AGE_WIDTH  = 5
) (
    input  logic                  first,
    input  logic                  key_on,
    input  logic                  busy,
    input  logic [NOTE_WIDTH-1:0] note,
    input  logic [NOTE_WIDTH-1:0] req_note,
    input  logic [AGE_WIDTH-1:0]  age,
    input  logic                  match_found,
    input  logic                  free_found,
    input  logic [AGE_WIDTH-1:0]  best_age,
    output logic                  take_match,
    output logic                  take_free,
    output logic                  take_oldest
);
    // Strict compares keep the lowest index on ties.
    assign take_match  = (first || !match_found) && key_on && (note == req_note);
    assign take_free   = (first || !free_found) && !busy;
    assign take_oldest = first || (age > best_age);
endmodule

// File: rtl/voice_allocator.sv
// voice_allocator: picks the voice that sounds or releases each MIDI note.
//   reg_clk/reset_reg        - clock, async active-high reset
//   req_*                    - decoded note-on/off request (valid/ready)
//   env_done                 - per-voice release-finished pulses
//   evt_*                    - one-cycle assignment strobe and payload
//   keys_on/voice_busy       - per-voice gate and gated-or-releasing state
//   active_keys              - registered popcount of keys_on
// A request is scanned one voice per cycle, then issued in one cycle.
module voice_allocator #(
    parameter int VOICES     = 32,
    parameter int V_WIDTH    = 5,
    parameter int NOTE_WIDTH = 7,
    parameter int VEL_WIDTH  = 7
) (
    input  logic                  reg_clk,
    input  logic                  reset_reg,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_on,
    input  logic [NOTE_WIDTH-1:0] req_note,
    input  logic [VEL_WIDTH-1:0]  req_vel,
    input  logic [VOICES-1:0]     env_done,
    output logic                  evt_valid,
    output logic [V_WIDTH-1:0]    evt_voice,
    output logic                  evt_gate,
    output logic [NOTE_WIDTH-1:0] evt_note,
    output logic [VEL_WIDTH-1:0]  evt_vel,
    output logic                  evt_steal,
    output logic [VOICES-1:0]     keys_on,
    output logic [VOICES-1:0]     voice_busy,
    output logic [V_WIDTH:0]      active_keys
);
    import synth_pkg::*;

    localparam logic [V_WIDTH-1:0] LAST_IDX = V_WIDTH'(VOICES - 1);
    localparam logic [V_WIDTH-1:0] AGE_MAX  = V_WIDTH'(VOICES - 1);

    alloc_state_t state, state_nx;

    logic [V_WIDTH-1:0]    scan_idx;
    logic                  lat_gate_on;   // note-on with nonzero velocity
    logic [NOTE_WIDTH-1:0] lat_note;
    logic [VEL_WIDTH-1:0]  lat_vel;

    logic [NOTE_WIDTH-1:0] note_r [VOICES];
    logic [VEL_WIDTH-1:0]  vel_r  [VOICES];
    logic [V_WIDTH-1:0]    age_r  [VOICES];

    logic                  match_found, free_found;
    logic [V_WIDTH-1:0]    match_idx, free_idx, old_idx, old_age;
    logic                  take_match, take_free, take_oldest;

    note_evt_t             evt_r;
    logic                  evt_voice_unused;

    logic                  accept, alloc, release_v;
    logic [V_WIDTH-1:0]    target;

    assign accept    = req_valid && req_ready;
    assign alloc     = (state == ST_ISSUE) && lat_gate_on;
    assign release_v = (state == ST_ISSUE) && !lat_gate_on && match_found;
    assign target    = match_found ? match_idx : (free_found ? free_idx : old_idx);

    assign evt_gate  = evt_r.gate;
    assign evt_voice = evt_r.voice[V_WIDTH-1:0];
    assign evt_note  = evt_r.note;
    assign evt_vel   = evt_r.vel;
    assign evt_voice_unused = ^evt_r.voice;

    voice_scan_cmp #(.NOTE_WIDTH(NOTE_WIDTH), .AGE_WIDTH(V_WIDTH)) u_cmp (
        .first       (scan_idx == '0),
        .key_on      (keys_on[scan_idx]),
        .busy        (voice_busy[scan_idx]),
        .note        (note_r[scan_idx]),
        .req_note    (lat_note),
        .age         (age_r[scan_idx]),
        .match_found (match_found),
        .free_found  (free_found),
        .best_age    (old_age),
        .take_match  (take_match),
        .take_free   (take_free),
        .take_oldest (take_oldest)
    );

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (accept) state_nx = ST_SCAN;
            ST_SCAN:  if (scan_idx == LAST_IDX) state_nx = ST_ISSUE;
            ST_ISSUE: state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge reg_clk or posedge reset_reg) begin
        if (reset_reg) state <= ST_IDLE;
        else           state <= state_nx;
    end

    // Request latch, scan cursor and running candidates.
    always_ff @(posedge reg_clk or posedge reset_reg) begin
        if (reset_reg) begin
            req_ready   <= 1'b1;
            scan_idx    <= '0;
            lat_gate_on <= 1'b0;
            lat_note    <= '0;
            lat_vel     <= '0;
            match_found <= 1'b0;
            free_found  <= 1'b0;
            match_idx   <= '0;
            free_idx    <= '0;
            old_idx     <= '0;
            old_age     <= '0;
        end else begin
            // Registered ready: low from the cycle after acceptance until the
            // cycle after the issue slot.
            req_ready <= (state == ST_IDLE) && !accept;
            if (accept) begin
                lat_gate_on <= req_on && (req_vel != '0);
                lat_note    <= req_note;
                lat_vel     <= req_vel;
                scan_idx    <= '0;
            end
            if (state == ST_SCAN) begin
                scan_idx <= (scan_idx == LAST_IDX) ? '0 : scan_idx + 1'b1;
                if (scan_idx == '0) begin
                    match_found <= take_match;
                    free_found  <= take_free;
                end else begin
                    if (take_match) match_found <= 1'b1;
                    if (take_free)  free_found  <= 1'b1;
                end
                if (take_match) match_idx <= scan_idx;
                if (take_free)  free_idx  <= scan_idx;
                if (take_oldest) begin
                    old_idx <= scan_idx;
                    old_age <= age_r[scan_idx];
                end
            end
        end
    end

    // Per-voice state and event register.
    always_ff @(posedge reg_clk or posedge reset_reg) begin
        if (reset_reg) begin
            keys_on     <= '0;
            voice_busy  <= '0;
            active_keys <= '0;
            evt_valid   <= 1'b0;
            evt_steal   <= 1'b0;
            evt_r       <= '0;
            for (int v = 0; v < VOICES; v++) begin
                note_r[v] <= '0;
                vel_r[v]  <= '0;
                age_r[v]  <= '0;
            end
        end else begin
            evt_valid   <= 1'b0;
            active_keys <= (V_WIDTH+1)'($countones(keys_on));
            for (int v = 0; v < VOICES; v++) begin
                if (alloc && (V_WIDTH'(v) == target)) begin
                    // Allocation overrides a coincident env_done on this voice.
                    keys_on[v]    <= 1'b1;
                    voice_busy[v] <= 1'b1;
                    note_r[v]     <= lat_note;
                    vel_r[v]      <= lat_vel;
                    age_r[v]      <= '0;
                end else begin
                    if (alloc && voice_busy[v] && (age_r[v] != AGE_MAX))
                        age_r[v] <= age_r[v] + 1'b1;
                    if (release_v && (V_WIDTH'(v) == match_idx))
                        keys_on[v] <= 1'b0;
                    if (env_done[v] && !keys_on[v])
                        voice_busy[v] <= 1'b0;
                end
            end
            if (alloc) begin
                evt_valid   <= 1'b1;
                evt_steal   <= !match_found && !free_found;
                evt_r.gate  <= 1'b1;
                evt_r.voice <= MAX_V_WIDTH'(target);
                evt_r.note  <= lat_note;
                evt_r.vel   <= lat_vel;
            end else if (release_v) begin
                evt_valid   <= 1'b1;
                evt_steal   <= 1'b0;
                evt_r.gate  <= 1'b0;
                evt_r.voice <= MAX_V_WIDTH'(match_idx);
                evt_r.note  <= note_r[match_idx];
                evt_r.vel   <= vel_r[match_idx];
            end
        end
    end
endmodule

// File: tb/tb_voice_allocator.sv
module tb_voice_allocator;
    localparam int NV = 4;
    localparam int VW = 2;

    logic          reg_clk = 1'b0;
    logic          reset_reg = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_on = 1'b0;
    logic [6:0]    req_note = '0;
    logic [6:0]    req_vel = '0;
    logic [NV-1:0] env_done = '0;
    logic          evt_valid;
    logic [VW-1:0] evt_voice;
    logic          evt_gate;
    logic [6:0]    evt_note;
    logic [6:0]    evt_vel;
    logic          evt_steal;
    logic [NV-1:0] keys_on;
    logic [NV-1:0] voice_busy;
    logic [VW:0]   active_keys;

    voice_allocator #(.VOICES(NV), .V_WIDTH(VW), .NOTE_WIDTH(7), .VEL_WIDTH(7)) dut (
        .reg_clk(reg_clk), .reset_reg(reset_reg),
        .req_valid(req_valid), .req_ready(req_ready), .req_on(req_on),
        .req_note(req_note), .req_vel(req_vel), .env_done(env_done),
        .evt_valid(evt_valid), .evt_voice(evt_voice), .evt_gate(evt_gate),
        .evt_note(evt_note), .evt_vel(evt_vel), .evt_steal(evt_steal),
        .keys_on(keys_on), .voice_busy(voice_busy), .active_keys(active_keys)
    );

    always #5 reg_clk = ~reg_clk;

    int cyc = 0;
    always @(posedge reg_clk) cyc <= cyc + 1;

    typedef struct {
        int voice;
        int gate;
        int note;
        int vel;
        int steal;
        int at;
    } exp_t;
    exp_t expq[$];

    int checks = 0;
    int errors = 0;

    // Reference model: voice table in plain arrays.
    bit m_keys[NV];
    bit m_busy[NV];
    int m_note[NV];
    int m_vel[NV];
    int m_age[NV];

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int mvec_keys();
        int r = 0;
        for (int i = 0; i < NV; i++) if (m_keys[i]) r |= (1 << i);
        return r;
    endfunction

    function automatic int mvec_busy();
        int r = 0;
        for (int i = 0; i < NV; i++) if (m_busy[i]) r |= (1 << i);
        return r;
    endfunction

    function automatic int mcount();
        int r = 0;
        for (int i = 0; i < NV; i++) r += int'(m_keys[i]);
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NV; i++) begin
            m_keys[i] = 0; m_busy[i] = 0; m_note[i] = 0; m_vel[i] = 0; m_age[i] = 0;
        end
    endtask

    // Applies one request to the model and queues the event it should produce.
    // env_mask is a release pulse landing in the issue cycle.
    task automatic model_req(input bit on, input int note, input int vel, input int at, input int env_mask);
        int m = -1;
        int f = -1;
        int o = 0;
        int t;
        exp_t e;
        for (int i = 0; i < NV; i++) if (m < 0 && m_keys[i] && m_note[i] == note) m = i;
        if (on && vel != 0) begin
            for (int i = 0; i < NV; i++) if (f < 0 && !m_busy[i]) f = i;
            for (int i = 0; i < NV; i++) if (m_age[i] > m_age[o]) o = i;
            t = (m >= 0) ? m : ((f >= 0) ? f : o);
            for (int i = 0; i < NV; i++)
                if (i != t && m_busy[i] && m_age[i] < NV - 1) m_age[i]++;
            m_keys[t] = 1; m_busy[t] = 1; m_note[t] = note; m_vel[t] = vel; m_age[t] = 0;
            e = '{voice: t, gate: 1, note: note, vel: vel, steal: int'(m < 0 && f < 0), at: at};
            expq.push_back(e);
        end else if (m >= 0) begin
            e = '{voice: m, gate: 0, note: m_note[m], vel: m_vel[m], steal: 0, at: at};
            expq.push_back(e);
            m_keys[m] = 0;
        end
        for (int i = 0; i < NV; i++) if (env_mask[i] && !m_keys[i]) m_busy[i] = 0;
    endtask

    // Monitor: every strobe must match the oldest queued expectation.
    always @(negedge reg_clk) begin
        exp_t e;
        if (!reset_reg && evt_valid) begin
            if (expq.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_evt: voice %0d gate %0d note %0d at cycle %0d, none expected",
                         evt_voice, evt_gate, evt_note, cyc);
            end else begin
                e = expq.pop_front();
                chk("evt_cycle", cyc, e.at);
                chk("evt_voice", int'(evt_voice), e.voice);
                chk("evt_gate",  int'(evt_gate),  e.gate);
                chk("evt_note",  int'(evt_note),  e.note);
                chk("evt_vel",   int'(evt_vel),   e.vel);
                chk("evt_steal", int'(evt_steal), e.steal);
            end
        end
    end

    task automatic do_reset();
        @(negedge reg_clk);
        reset_reg = 1'b1;
        req_valid = 1'b0;
        env_done  = '0;
        @(negedge reg_clk);
        model_reset();
        chk("rst_ready", int'(req_ready), 1);
        chk("rst_evt_valid", int'(evt_valid), 0);
        chk("rst_keys", int'(keys_on), 0);
        chk("rst_busy", int'(voice_busy), 0);
        chk("rst_active", int'(active_keys), 0);
        reset_reg = 1'b0;
        @(negedge reg_clk);
    endtask

    task automatic do_req(input bit on, input int note, input int vel, input int env_mask);
        int acc;
        @(negedge reg_clk);
        for (int k = 0; k < 40 && !req_ready; k++) @(negedge reg_clk);
        chk("ready_before_req", int'(req_ready), 1);
        req_valid = 1'b1;
        req_on    = on;
        req_note  = 7'(note);
        req_vel   = 7'(vel);
        @(posedge reg_clk);
        #1;
        acc = cyc;
        req_valid = 1'b0;
        model_req(on, note, vel, acc + NV + 1, env_mask);
        @(negedge reg_clk);
        chk("ready_drop", int'(req_ready), 0);
        for (int k = 0; k < 20; k++) begin
            env_done = (cyc == acc + NV) ? NV'(env_mask) : '0;
            if (req_ready) break;
            @(negedge reg_clk);
        end
        env_done = '0;
        chk("ready_return_cycle", cyc, acc + NV + 2);
        chk("evt_pending", expq.size(), 0);
        chk("keys_on", int'(keys_on), mvec_keys());
        chk("voice_busy", int'(voice_busy), mvec_busy());
        chk("active_keys", int'(active_keys), mcount());
    endtask

    task automatic pulse_env(input int mask);
        @(negedge reg_clk);
        env_done = NV'(mask);
        @(negedge reg_clk);
        env_done = '0;
        for (int i = 0; i < NV; i++) if (mask[i] && !m_keys[i]) m_busy[i] = 0;
        chk("busy_after_env", int'(voice_busy), mvec_busy());
    endtask

    initial begin
        int on, note, vel;
        model_reset();
        repeat (2) @(negedge reg_clk);
        do_reset();

        // Fill the pool, then steal the oldest, retrigger, release.
        do_req(1, 60, 100, 0);
        do_req(1, 62, 101, 0);
        do_req(1, 64, 102, 0);
        do_req(1, 65, 103, 0);
        do_req(1, 67, 90, 0);
        do_req(1, 67, 50, 0);
        do_req(0, 67, 0, 0);
        pulse_env(1);
        do_req(1, 70, 80, 0);
        do_req(0, 72, 10, 0);
        do_req(1, 62, 0, 0);

        // Release pulse coinciding with the issue slot that allocates voice 2.
        do_reset();
        do_req(1, 60, 100, 0);
        do_req(1, 62, 100, 0);
        do_req(1, 64, 100, 4);

        // Reset in the middle of a scan: request is dropped, no strobe.
        @(negedge reg_clk);
        req_valid = 1'b1; req_on = 1'b1; req_note = 7'd66; req_vel = 7'd70;
        @(posedge reg_clk);
        #1;
        req_valid = 1'b0;
        repeat (2) @(negedge reg_clk);
        reset_reg = 1'b1;
        #1;
        model_reset();
        chk("midscan_evt_valid", int'(evt_valid), 0);
        chk("midscan_keys", int'(keys_on), 0);
        chk("midscan_busy", int'(voice_busy), 0);
        chk("midscan_active", int'(active_keys), 0);
        chk("midscan_ready", int'(req_ready), 1);
        repeat (2) @(negedge reg_clk);
        reset_reg = 1'b0;
        repeat (NV + 4) @(negedge reg_clk);
        chk("midscan_no_evt_keys", int'(keys_on), 0);

        // Randomized traffic over a small note range so matches are common.
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(7) == 0) begin
                pulse_env(int'($urandom_range((1 << NV) - 1)));
            end else begin
                on   = int'($urandom_range(1));
                note = 60 + int'($urandom_range(5));
                vel  = ($urandom_range(3) == 0) ? 0 : 1 + int'($urandom_range(126));
                do_req(on[0], note, vel, 0);
            end
        end

        repeat (NV + 4) @(negedge reg_clk);
        chk("final_queue_empty", expq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
